fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction loaded into IF/ID on flush and reset.
REQ-003 SHALL have ports: clk in 1 (single clock, all logic on rising edge); rst in 1 (reset is synchronous and active-high).
REQ-004 SHALL have ports: PCWrite in 1, IFID_RegWrite in 1, InstrFlush in 1 (hazard controls); BranchCtrl in 2 (00 PC+4, 01 branch, 10 jalr, 11 treated as 00).
REQ-005 SHALL have ports: pc_branch in 32 (branch target); pc_jalr in 32 (jalr target).
REQ-006 SHALL have ports: im_req out 1, im_addr out 32, im_ready in 1 (request accepted when im_req&&im_ready).
REQ-007 SHALL have ports: im_rvalid in 1, im_rdata in 32 (response, at least 1 cycle after acceptance).
REQ-008 SHALL have ports: ifid_pc out 32, ifid_instr out 32, ifid_valid out 1 (IF/ID register); fetch_stall out 1 (no instruction available this cycle).

Function
REQ-009 SHALL keep at most one imem request outstanding; im_addr = pc_q while im_req=1.
REQ-010 SHALL implement states BOOT, REQ, RESP, DROP; BOOT->REQ unconditionally one cycle after reset release.
REQ-011 REQ: im_req=1; on im_ready ->RESP; im_req/im_addr SHALL stay stable until accepted.
REQ-012 RESP: on im_rvalid, instruction available; ->REQ for next PC in same edge if consumed, else capture into hold register and ->REQ only after hold drains.
REQ-013 Instruction available = (RESP&&im_rvalid) || hold_valid; hold SHALL take priority over nothing else (hold and live response never coexist).
REQ-014 Consume when IFID_RegWrite=1, PCWrite=1, InstrFlush=0, instruction available: ifid_instr<=instr, ifid_pc<=pc_q, ifid_valid<=1, pc_q<=pc_q+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), hold_valid<=0.
REQ-015 IFID_RegWrite=1, InstrFlush=0, none available: ifid_valid<=0, ifid_instr<=NOP_INSTR (bubble); fetch_stall=1 combinationally.
REQ-016 Stall (IFID_RegWrite=0 or PCWrite=0, InstrFlush=0): IF/ID and pc_q SHALL hold; arriving response SHALL be captured in hold.
REQ-017 InstrFlush=1: ifid_valid<=0, ifid_instr<=NOP_INSTR, hold_valid<=0, pc_q<=pc_branch (01) or pc_jalr (10) or pc_q (00/11).
REQ-018 Flush with request outstanding (RESP without im_rvalid, or REQ accepted same cycle) SHALL ->DROP; DROP discards next im_rvalid then ->REQ; otherwise ->REQ.
REQ-019 Flush in RESP coincident with im_rvalid SHALL discard that response and ->REQ.
REQ-020 Priority: rst > InstrFlush > stall > consume/bubble.
REQ-021 im_rvalid outside RESP/DROP SHALL be ignored.

Reset
REQ-022 rst=1 SHALL set: pc_q=RESET_PC, state=BOOT, im_req=0, hold_valid=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, counters=0.
REQ-023 Reset mid-request SHALL abandon it; response arriving in BOOT SHALL be ignored.

Configuration
REQ-024 Macro FETCH_PERF_EN: defined -> outputs perf_stall_cnt (32, increments each cycle fetch_stall=1) and perf_flush_cnt (32, increments each InstrFlush=1 cycle), saturating at all-ones; undefined -> ports and counters absent, behaviour otherwise identical.

Structure
REQ-025 Shared package SHALL hold BranchCtrl encodings (PC4, PCB, PCJR), state enum, NOP_INSTR constant.
REQ-026 No sub-module; single module with FSM, PC register, hold register, IF/ID register.

Verification
REQ-027 Reset, im_ready=1, 1-cycle rvalid, im_rdata=0x00500093 -> first request addr 0x0; ifid_pc=0x0, ifid_instr=0x00500093, ifid_valid=1; next addr 0x4.
REQ-028 Response arrives while IFID_RegWrite=PCWrite=0 for 3 cycles -> IF/ID and pc_q held; instr loaded on first cycle controls return to 1; no extra request during stall.
REQ-029 InstrFlush=1, BranchCtrl=01, pc_branch=0x100 while in RESP -> ifid_valid=0, ifid_instr=0x13; late response dropped; next im_addr=0x100.
REQ-030 BranchCtrl=10, pc_jalr=0x2000 coincident with im_rvalid -> response discarded; next im_addr=0x2000.
REQ-031 im_ready low 4 cycles -> im_addr stable, ifid_valid=0, fetch_stall=1 each cycle; with FETCH_PERF_EN perf_stall_cnt=4.
REQ-032 pc_q=0xFFFFFFFC consumed -> next im_addr=0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - BranchCtrl encodings (PC4, PCB, PCJR); encoding 2'b11 behaves as PC4
//   - fetch FSM state enum
//   - default NOP instruction (addi x0, x0, 0)
//   - helper that selects the redirect PC for a flush
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam logic [1:0] PC4  = 2'b00;
   localparam logic [1:0] PCB  = 2'b01;
   localparam logic [1:0] PCJR = 2'b10;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10,
      DROP = 2'b11
   } fetch_state_t;

   // Flush target: branch or jalr target, otherwise refetch from the current PC.
   function automatic logic [31:0] redirect_pc(input logic [1:0]  i_ctrl,
                                               input logic [31:0] i_pc,
                                               input logic [31:0] i_pc_branch,
                                               input logic [31:0] i_pc_jalr);
      case (i_ctrl)
         PCB:     return i_pc_branch;
         PCJR:    return i_pc_jalr;
         default: return i_pc;
      endcase
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// one-entry hold register for responses that arrive while the pipe is stalled,
// and the IF/ID pipeline register.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   PCWrite            : 0 stalls the PC
//   IFID_RegWrite      : 0 stalls the IF/ID register
//   InstrFlush         : kill IF/ID, drop in-flight fetch, redirect PC
//   BranchCtrl[1:0]    : redirect select (PC4 / PCB / PCJR, 11 = PC4)
//   pc_branch, pc_jalr : redirect targets
//   im_req/im_addr/im_ready    : imem request handshake
//   im_rvalid/im_rdata         : imem response
//   ifid_pc/ifid_instr/ifid_valid : IF/ID register
//   fetch_stall        : no instruction available this cycle
//
// Configuration
//   FETCH_PERF_EN : when defined, adds saturating perf_stall_cnt and
//                   perf_flush_cnt outputs.
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFID_RegWrite,
   input  logic        InstrFlush,
   input  logic [1:0]  BranchCtrl,
   input  logic [31:0] pc_branch,
   input  logic [31:0] pc_jalr,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ready,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        fetch_stall
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [31:0] r_pc;
   logic        r_hold_valid;
   logic [31:0] r_hold_instr;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_instr;
   logic        r_ifid_valid;

   logic        w_live;
   logic        w_avail;
   logic        w_stall;
   logic        w_consume;
   logic [31:0] w_instr;

   // A live response only counts while nothing is parked in the hold register,
   // so the two sources are mutually exclusive.
   assign w_live    = (r_state == RESP) && im_rvalid && !r_hold_valid;
   assign w_avail   = w_live || r_hold_valid;
   assign w_stall   = !IFID_RegWrite || !PCWrite;
   assign w_consume = !InstrFlush && !w_stall && w_avail;
   assign w_instr   = r_hold_valid ? r_hold_instr : im_rdata;

   assign im_req      = (r_state == REQ);
   assign im_addr     = r_pc;
   assign ifid_pc     = r_ifid_pc;
   assign ifid_instr  = r_ifid_instr;
   assign ifid_valid  = r_ifid_valid;
   assign fetch_stall = !w_avail;

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BOOT: w_state_nxt = REQ;
         REQ: begin
            // A request accepted in the flush cycle still returns data that
            // must be thrown away.
            if (im_ready) w_state_nxt = InstrFlush ? DROP : RESP;
         end
         RESP: begin
            if (InstrFlush)
               w_state_nxt = (r_hold_valid || im_rvalid) ? REQ : DROP;
            else if (w_consume)
               w_state_nxt = REQ;
         end
         DROP: begin
            if (im_rvalid) w_state_nxt = REQ;
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= BOOT;
         r_pc         <= RESET_PC;
         r_hold_valid <= 1'b0;
         r_ifid_pc    <= 32'h0000_0000;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (InstrFlush) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_hold_valid <= 1'b0;
            r_pc         <= redirect_pc(BranchCtrl, r_pc, pc_branch, pc_jalr);
         end else if (w_stall) begin
            if (w_live) r_hold_valid <= 1'b1;
         end else if (w_avail) begin
            r_ifid_instr <= w_instr;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_hold_valid <= 1'b0;
         end else if (IFID_RegWrite) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
         end
      end
   end

   // NOTE: the hold data register has no reset; r_hold_valid qualifies it.
   always_ff @(posedge clk) begin
      if (!InstrFlush && w_stall && w_live) r_hold_instr <= im_rdata;
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall_cnt <= 32'h0000_0000;
         r_perf_flush_cnt <= 32'h0000_0000;
      end else begin
         if (fetch_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF))
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         if (InstrFlush && (r_perf_flush_cnt != 32'hFFFF_FFFF))
            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall_cnt;
   assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: reset state, first fetch, stall with hold,
// flush to branch/jalr targets, response drop, imem backpressure, PC wrap,
// BranchCtrl=11 and reset mid-request. The imem side is driven by hand.
// Optional perf counter checks when FETCH_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCWrite, IFID_RegWrite, InstrFlush;
   logic [1:0]  BranchCtrl;
   logic [31:0] pc_branch, pc_jalr;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready, im_rvalid;
   logic [31:0] im_rdata;
   logic [31:0] ifid_pc, ifid_instr;
   logic        ifid_valid, fetch_stall;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [31:0] stall_snap;
`endif

   int n_checks = 0;
   int n_bad    = 0;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .PCWrite       (PCWrite),
      .IFID_RegWrite (IFID_RegWrite),
      .InstrFlush    (InstrFlush),
      .BranchCtrl    (BranchCtrl),
      .pc_branch     (pc_branch),
      .pc_jalr       (pc_jalr),
      .im_req        (im_req),
      .im_addr       (im_addr),
      .im_ready      (im_ready),
      .im_rvalid     (im_rvalid),
      .im_rdata      (im_rdata),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid),
      .fetch_stall   (fetch_stall)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; PCWrite = 1'b1; IFID_RegWrite = 1'b1; InstrFlush = 1'b0;
      BranchCtrl = 2'b00; pc_branch = '0; pc_jalr = '0;
      im_ready = 1'b0; im_rvalid = 1'b0; im_rdata = '0;

      // Reset state
      step(); step();
      #1;
      check("rst_im_req", im_req, 0);
      check("rst_ifid_valid", ifid_valid, 0);
      check("rst_ifid_instr", ifid_instr, 32'h13);
      check("rst_ifid_pc", ifid_pc, 0);

      // First fetch: BOOT -> REQ one edge after release
      rst = 1'b0;
      step(); #1;
      check("boot_im_req", im_req, 1);
      check("boot_im_addr", im_addr, 0);
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h0050_0093; #1;
      check("resp_fetch_stall", fetch_stall, 0);
      check("resp_im_req", im_req, 0);
      step();
      im_rvalid = 1'b0; #1;
      check("f1_ifid_pc", ifid_pc, 0);
      check("f1_ifid_instr", ifid_instr, 32'h0050_0093);
      check("f1_ifid_valid", ifid_valid, 1);
      check("f1_next_addr", im_addr, 32'h4);
      check("f1_next_req", im_req, 1);

      // Stall: response captured into hold, IF/ID frozen for 3 cycles
      PCWrite = 1'b0; IFID_RegWrite = 1'b0; im_ready = 1'b1;
      step();
      im_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h1111_1111;
      step();
      im_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("stl_ifid_instr", ifid_instr, 32'h0050_0093);
         check("stl_ifid_pc", ifid_pc, 0);
         check("stl_ifid_valid", ifid_valid, 1);
         check("stl_no_req", im_req, 0);
         step();
      end
      PCWrite = 1'b1; IFID_RegWrite = 1'b1; #1;
      check("stl_hold_avail", fetch_stall, 0);
      step(); #1;
      check("stl_rel_instr", ifid_instr, 32'h1111_1111);
      check("stl_rel_pc", ifid_pc, 32'h4);
      check("stl_rel_valid", ifid_valid, 1);
      check("stl_rel_addr", im_addr, 32'h8);
      check("stl_rel_req", im_req, 1);

      // Flush to branch target while waiting in RESP; late response dropped
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; InstrFlush = 1'b1; BranchCtrl = 2'b01; pc_branch = 32'h100;
      step();
      InstrFlush = 1'b0; BranchCtrl = 2'b00; #1;
      check("brf_ifid_valid", ifid_valid, 0);
      check("brf_ifid_instr", ifid_instr, 32'h13);
      check("brf_drop_noreq", im_req, 0);
      im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF; #1;
      check("brf_drop_stall", fetch_stall, 1);
      step();
      im_rvalid = 1'b0; #1;
      check("brf_req", im_req, 1);
      check("brf_addr", im_addr, 32'h100);
      check("brf_not_loaded", ifid_instr, 32'h13);
      check("brf_valid0", ifid_valid, 0);

      // Flush to jalr target coincident with response
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hCAFE_F00D;
      InstrFlush = 1'b1; BranchCtrl = 2'b10; pc_jalr = 32'h2000;
      step();
      im_rvalid = 1'b0; InstrFlush = 1'b0; BranchCtrl = 2'b00; #1;
      check("jrf_req", im_req, 1);
      check("jrf_addr", im_addr, 32'h2000);
      check("jrf_valid0", ifid_valid, 0);
      check("jrf_instr", ifid_instr, 32'h13);

      // Backpressure: im_ready low for 4 cycles
`ifdef FETCH_PERF_EN
      stall_snap = perf_stall_cnt;
`endif
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_addr", im_addr, 32'h2000);
         check("bp_req", im_req, 1);
         check("bp_valid0", ifid_valid, 0);
         check("bp_fetch_stall", fetch_stall, 1);
         step();
      end
`ifdef FETCH_PERF_EN
      check("perf_stall_delta", perf_stall_cnt - stall_snap, 32'd4);
      check("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

      // PC wrap from 0xFFFFFFFC
      InstrFlush = 1'b1; BranchCtrl = 2'b01; pc_branch = 32'hFFFF_FFFC;
      step();
      InstrFlush = 1'b0; BranchCtrl = 2'b00; #1;
      check("wrap_addr", im_addr, 32'hFFFF_FFFC);
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h1234_5678;
      step();
      im_rvalid = 1'b0; #1;
      check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
      check("wrap_ifid_instr", ifid_instr, 32'h1234_5678);
      check("wrap_next_addr", im_addr, 32'h0);

      // BranchCtrl=11 behaves as PC+4 select: PC unchanged on flush
      InstrFlush = 1'b1; BranchCtrl = 2'b11; pc_branch = 32'h500; pc_jalr = 32'h600;
      step();
      InstrFlush = 1'b0; BranchCtrl = 2'b00; #1;
      check("bc11_addr", im_addr, 32'h0);
      check("bc11_valid0", ifid_valid, 0);

      // Reset mid-request; response arriving in BOOT ignored
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; rst = 1'b1;
      step();
      #1;
      check("mid_rst_req", im_req, 0);
      check("mid_rst_ifid_pc", ifid_pc, 0);
      rst = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h0000_0BAD;
      step();
      im_rvalid = 1'b0; #1;
      check("mid_rst_boot_req", im_req, 1);
      check("mid_rst_addr", im_addr, 0);
      check("mid_rst_valid0", ifid_valid, 0);
      check("mid_rst_instr", ifid_instr, 32'h13);

      // Clean fetch after reset
      im_ready = 1'b1;
      step();
      im_ready = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h00A0_0113;
      step();
      im_rvalid = 1'b0; #1;
      check("post_instr", ifid_instr, 32'h00A0_0113);
      check("post_pc", ifid_pc, 0);
      check("post_addr", im_addr, 32'h4);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
